// File: rtl/dtg_param.sv
// dtg_param: parametrised display timing generator with registered sync/video/strobe outputs.
// Optional DTG_FRAME_CNT_EN adds a 16-bit completed-frame counter output.
module dtg_param #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int CW = 12
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          enable,
  output logic          horiz_sync,
  output logic          vert_sync,
  output logic          video_on,
  output logic [CW-1:0] pixel_row,
  output logic [CW-1:0] pixel_column,
  output logic          line_start,
`ifdef DTG_FRAME_CNT_EN
  output logic          frame_start,
  output logic [15:0]   frame_count
`else
  output logic          frame_start
`endif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  if ((2 ** CW) < H_TOTAL || (2 ** CW) < V_TOTAL) begin : g_cw_check
    $error("dtg_param: CW too small for H_TOTAL/V_TOTAL");
  end
  logic [CW-1:0] hc_q, vc_q, hc_d, vc_d, col_q, row_q;
  logic von_q, hs_q, vs_q, ls_q, fs_q;
  logic h_last, v_last, von_d, hs_d, vs_d, ls_d, fs_d;
  always_comb begin
    h_last = hc_q == CW'(H_TOTAL - 1);
    v_last = vc_q == CW'(V_TOTAL - 1);
    hc_d = h_last ? '0 : hc_q + 1'b1;
    vc_d = h_last ? (v_last ? '0 : vc_q + 1'b1) : vc_q;
    von_d = (hc_q < CW'(H_ACTIVE)) && (vc_q < CW'(V_ACTIVE));
    hs_d = (hc_q >= CW'(H_ACTIVE + H_FP) && hc_q < CW'(H_ACTIVE + H_FP + H_SYNC)) ? HS_POL : ~HS_POL;
    vs_d = (vc_q >= CW'(V_ACTIVE + V_FP) && vc_q < CW'(V_ACTIVE + V_FP + V_SYNC)) ? VS_POL : ~VS_POL;
    ls_d = hc_q == '0;
    fs_d = ls_d && vc_q == '0;
  end
  // Frozen timing keeps every level output; only the strobes drop.
  always_ff @(posedge clock) begin
    if (rst) begin
      hc_q <= '0;
      vc_q <= '0;
      col_q <= '0;
      row_q <= '0;
      von_q <= 1'b0;
      hs_q <= ~HS_POL;
      vs_q <= ~VS_POL;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else if (enable) begin
      hc_q <= hc_d;
      vc_q <= vc_d;
      col_q <= hc_q;
      row_q <= vc_q;
      von_q <= von_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      ls_q <= ls_d;
      fs_q <= fs_d;
    end else begin
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end
  end
`ifdef DTG_FRAME_CNT_EN
  logic [15:0] fc_q;
  logic seen_q;
  // The first frame after reset is not a completed frame, so it only arms the counter.
  always_ff @(posedge clock) begin
    if (rst) begin
      fc_q <= '0;
      seen_q <= 1'b0;
    end else if (enable && fs_d) begin
      seen_q <= 1'b1;
      fc_q <= seen_q ? fc_q + 1'b1 : fc_q;
    end
  end
  assign frame_count = fc_q;
`endif
  assign horiz_sync = hs_q;
  assign vert_sync = vs_q;
  assign video_on = von_q;
  assign pixel_row = row_q;
  assign pixel_column = col_q;
  assign line_start = ls_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_dtg_param.sv
// tb_dtg_param: checks a default-timing and a tiny-timing dtg_param against a position-index model.
module tb_dtg_param;
  logic clk = 1'b0, rst = 1'b1, en = 1'b1;
  always #5 clk = ~clk;
  logic hs0, vs0, von0, ls0, fs0, hs1, vs1, von1, ls1, fs1;
  logic [11:0] col0, row0, col1, row1;
`ifdef DTG_FRAME_CNT_EN
  logic [15:0] fc0, fc1;
`endif
  dtg_param dut0 (
    .clock(clk), .rst(rst), .enable(en), .horiz_sync(hs0), .vert_sync(vs0), .video_on(von0),
    .pixel_row(row0), .pixel_column(col0), .line_start(ls0),
`ifdef DTG_FRAME_CNT_EN
    .frame_start(fs0), .frame_count(fc0)
`else
    .frame_start(fs0)
`endif
  );
  dtg_param #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1),
              .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1), .CW(12)) dut1 (
    .clock(clk), .rst(rst), .enable(en), .horiz_sync(hs1), .vert_sync(vs1), .video_on(von1),
    .pixel_row(row1), .pixel_column(col1), .line_start(ls1),
`ifdef DTG_FRAME_CNT_EN
    .frame_start(fs1), .frame_count(fc1)
`else
    .frame_start(fs1)
`endif
  );
  int checks = 0, errors = 0;
  typedef struct {int col, row, von, hs, vs, ls, fs, fc;} exp_t;
  // Output state for the p-th pixel advanced since reset, from plain division.
  function automatic exp_t model(int p, int ha, int hf, int hsw, int hb, int va, int vf, int vsw, int vb, int hp, int vp);
    exp_t e;
    int ht, vt;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    e.col = p % ht;
    e.row = (p / ht) % vt;
    e.von = (e.col < ha && e.row < va) ? 1 : 0;
    e.hs = (e.col >= ha + hf && e.col < ha + hf + hsw) ? hp : 1 - hp;
    e.vs = (e.row >= va + vf && e.row < va + vf + vsw) ? vp : 1 - vp;
    e.ls = (e.col == 0) ? 1 : 0;
    e.fs = (e.col == 0 && e.row == 0) ? 1 : 0;
    e.fc = (p / (ht * vt)) % 65536;
    return e;
  endfunction
  function automatic exp_t rst_exp(int hp, int vp);
    exp_t e;
    e.col = 0; e.row = 0; e.von = 0; e.hs = 1 - hp; e.vs = 1 - vp; e.ls = 0; e.fs = 0; e.fc = 0;
    return e;
  endfunction
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  int p = 0;
  bit valid = 0;
  exp_t e0, e1;
  always @(posedge clk) begin
    bit r, e;
    r = rst;
    e = en;
    #1;
    if (r) begin
      valid = 1; p = 0; e0 = rst_exp(0, 0); e1 = rst_exp(1, 1);
    end else if (e) begin
      e0 = model(p, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0);
      e1 = model(p, 8, 2, 2, 2, 4, 1, 1, 1, 1, 1);
      p++;
    end else begin
      e0.ls = 0; e0.fs = 0; e1.ls = 0; e1.fs = 0;
    end
    if (valid) begin
      chk("d0_col", col0, e0.col); chk("d0_row", row0, e0.row); chk("d0_von", von0, e0.von);
      chk("d0_hs", hs0, e0.hs); chk("d0_vs", vs0, e0.vs); chk("d0_ls", ls0, e0.ls); chk("d0_fs", fs0, e0.fs);
      chk("d1_col", col1, e1.col); chk("d1_row", row1, e1.row); chk("d1_von", von1, e1.von);
      chk("d1_hs", hs1, e1.hs); chk("d1_vs", vs1, e1.vs); chk("d1_ls", ls1, e1.ls); chk("d1_fs", fs1, e1.fs);
`ifdef DTG_FRAME_CNT_EN
      chk("d0_fc", fc0, e0.fc); chk("d1_fc", fc1, e1.fc);
`endif
    end
  end
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic wait_pos(int c, int r, int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (col0 == c && (r < 0 || row0 == r)) return;
    end
    chk("wait_pos_timeout", 1, 0);
  endtask
  task automatic wait_fs1(output int n);
    n = 0;
    for (int i = 0; i < 500; i++) begin
      step();
      n++;
      if (fs1) return;
    end
    chk("wait_fs1_timeout", 1, 0);
  endtask
  initial begin
    int n_hs, n_ls, wrap, prev, n, n_vs, n_von;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    step();
    chk("first_col", col0, 0); chk("first_row", row0, 0); chk("first_von", von0, 1);
    chk("first_ls", ls0, 1); chk("first_fs", fs0, 1); chk("first_hs", hs0, 1); chk("first_vs", vs0, 1);
    chk("first_hs_d1", hs1, 0);
    step();
    chk("second_col", col0, 1); chk("second_ls", ls0, 0); chk("second_fs", fs0, 0);
    n_hs = 0; n_ls = 0; wrap = 0; prev = 1;
    for (int i = 0; i < 800; i++) begin
      step();
      if (!hs0) n_hs++;
      if (ls0) n_ls++;
      if (col0 == 0 && prev == 799) wrap++;
      prev = col0;
    end
    chk("line_hs_low", n_hs, 96); chk("line_ls_count", n_ls, 1); chk("line_wrap", wrap, 1);
    wait_pos(100, 5, 6000);
    en = 1'b0;
    repeat (10) begin
      step();
      chk("pause_col", col0, 100); chk("pause_ls", ls0, 0);
    end
    en = 1'b1;
    step();
    chk("resume_col", col0, 101);
    wait_pos(799, 5, 1000);
    en = 1'b0;
    repeat (10) begin
      step();
      chk("pause2_col", col0, 799); chk("pause2_ls", ls0, 0);
    end
    en = 1'b1;
    step();
    chk("resume2_col", col0, 0); chk("resume2_row", row0, 6); chk("resume2_ls", ls0, 1);
    step();
    chk("resume2_ls_once", ls0, 0);
    repeat (3000) begin
      en = ($urandom_range(0, 3) != 0);
      step();
    end
    en = 1'b1;
    wait_pos(700, -1, 2000);
    rst = 1'b1;
    step();
    chk("rst_col", col0, 0); chk("rst_row", row0, 0); chk("rst_von", von0, 0); chk("rst_hs", hs0, 1);
    chk("rst_vs", vs0, 1); chk("rst_ls", ls0, 0); chk("rst_fs", fs0, 0);
    rst = 1'b0;
    step();
    chk("post_rst_col", col0, 0); chk("post_rst_row", row0, 0); chk("post_rst_fs", fs0, 1);
    n = 0; n_vs = 0; n_von = 0;
    for (int i = 0; i < 500; i++) begin
      step();
      n++;
      if (vs1) n_vs++;
      if (von1) n_von++;
      if (fs1) break;
    end
    chk("d1_frame_period", n, 98); chk("d1_vs_high", n_vs, 14); chk("d1_von_count", n_von, 32);
    wait_fs1(n);
    chk("d1_frame_period2", n, 98);
    wait_fs1(n);
`ifdef DTG_FRAME_CNT_EN
    chk("d1_frame_count_3", fc1, 3);
`endif
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
